// File: rtl/cpu_core.sv
// cpu_core: multi-cycle fetch/decode/execute/memory/writeback CPU on a req/ack motherboard bus.
// Define CPU_TRACE_EN to compile a per-instruction $display trace; default build has none.
module cpu_core #(
  parameter int unsigned           word_width = 32,
  parameter int unsigned           REG_COUNT  = 16,
  parameter logic [word_width-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] addr,
  output logic [word_width-1:0] data_out,
  input  logic [word_width-1:0] data_in
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpLdi  = 4'h6;
  localparam logic [3:0] OpLd   = 4'h7;
  localparam logic [3:0] OpSt   = 4'h8;
  localparam logic [3:0] OpBeqz = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpHlt  = 4'hF;

  typedef enum logic [2:0] {
    StReset, StFetch, StDecode, StExec, StMem, StWb, StHlt
  } state_e;

  state_e                state;
  logic [word_width-1:0] pc, ir, op_a, op_b, op_d, result;
  logic [word_width-1:0] rf [REG_COUNT];
  logic                  flag_z, flag_c, req_rd, req_wr, halted, illegal;

  logic [3:0]            op, rd, rs1, rs2;
  logic [word_width-1:0] imm, ea, br_pc, alu_res;
  logic [word_width:0]   alu_ext;
  logic                  alu_c, ack, is_illegal;
  logic                  unused;

  assign op         = ir[31:28];
  assign rd         = ir[27:24];
  assign rs1        = ir[23:20];
  assign rs2        = ir[19:16];
  assign imm        = word_width'(ir[15:0]);
  assign ea         = op_a + imm;
  assign br_pc      = (op == OpJmp || op_d == '0) ? imm : pc;
  assign ack        = mobo_stat[0];
  assign is_illegal = op inside {[4'hB:4'hE]};
  assign mobo_ctrl  = {{(word_width-4){1'b0}}, illegal, halted, req_wr, req_rd};
  // Flags are architectural state with no consumer instruction yet.
  assign unused     = ^{mobo_stat[word_width-1:1], flag_z, flag_c};

  function automatic logic [word_width-1:0] rf_read(input logic [3:0] idx);
    if ({28'd0, idx} < REG_COUNT) return rf[idx];
    return '0;
  endfunction

  // Carry for ADD, borrow for SUB: both appear in the extra top bit.
  always_comb begin
    alu_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OpAdd: begin
        alu_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = alu_ext[word_width-1:0];
        alu_c   = alu_ext[word_width];
      end
      OpSub: begin
        alu_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res = alu_ext[word_width-1:0];
        alu_c   = alu_ext[word_width];
      end
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StReset;
      pc       <= RESET_PC;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_d     <= '0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      req_rd   <= 1'b0;
      req_wr   <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        StReset: begin
          req_rd <= 1'b1;
          addr   <= pc;
          state  <= StFetch;
        end
        StFetch: begin
          if (ack) begin
            ir     <= data_in;
            pc     <= pc + word_width'(1);
            req_rd <= 1'b0;
            state  <= StDecode;
          end
        end
        StDecode: begin
          op_a <= rf_read(rs1);
          op_b <= rf_read(rs2);
          op_d <= rf_read(rd);
          if (op == OpHlt || is_illegal) begin
            halted  <= 1'b1;
            illegal <= is_illegal;
            state   <= StHlt;
          end else if (op == OpNop) begin
            req_rd <= 1'b1;
            addr   <= pc;
            state  <= StFetch;
          end else begin
            state <= StExec;
          end
        end
        StExec: begin
          if (op == OpLd || op == OpSt) begin
            addr <= ea;
            if (op == OpLd) begin
              req_rd <= 1'b1;
            end else begin
              req_wr   <= 1'b1;
              data_out <= op_d;
            end
            state <= StMem;
          end else if (op == OpBeqz || op == OpJmp) begin
            pc     <= br_pc;
            addr   <= br_pc;
            req_rd <= 1'b1;
            state  <= StFetch;
          end else begin
            result <= (op == OpLdi) ? imm : alu_res;
            if (op != OpLdi) begin
              flag_c <= alu_c;
              flag_z <= (alu_res == '0);
            end
            state <= StWb;
          end
        end
        StMem: begin
          if (ack) begin
            if (req_rd) begin
              result <= data_in;
              req_rd <= 1'b0;
              state  <= StWb;
            end else begin
              req_wr <= 1'b0;
              req_rd <= 1'b1;
              addr   <= pc;
              state  <= StFetch;
            end
          end
        end
        StWb: begin
          if ({28'd0, rd} < REG_COUNT) rf[rd] <= result;
          req_rd <= 1'b1;
          addr   <= pc;
          state  <= StFetch;
        end
        StHlt:   state <= StHlt;
        default: state <= StReset;
      endcase
`ifdef CPU_TRACE_EN
      if (state == StWb) begin
        $display("[trace] pc=%h ir=%h state=%s rd=%0d val=%h",
                 pc - word_width'(1), ir, state.name(), rd, result);
      end else if ((state == StDecode && op == OpNop) ||
                   (state == StExec && (op == OpBeqz || op == OpJmp)) ||
                   (state == StMem && ack && req_wr)) begin
        $display("[trace] pc=%h ir=%h state=%s rd=%0d val=-",
                 pc - word_width'(1), ir, state.name(), rd);
      end else if (state == StDecode && (op == OpHlt || is_illegal)) begin
        $display("[trace] pc=%h ir=%h state=%s halt", pc - word_width'(1), ir, state.name());
        for (int i = 0; i < REG_COUNT; i++) $display("[trace]   r%0d=%h", i, rf[i]);
      end
`endif
    end
  end

endmodule
